// File: rtl/fifo_w8_r16.sv
// Single-clock FIFO, byte-wide write side and word-wide (two bytes) read side.
// Registered read: dout updates on the edge that accepts a read.
module fifo_w8_r16 #(
  parameter int DIN_WIDTH = 8,
  parameter int WR_DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [DIN_WIDTH-1:0]     din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [2*DIN_WIDTH-1:0]   dout,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(WR_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(WR_DEPTH);
  localparam logic [AW:0] CNT_PAIR = (AW+1)'(2);

  logic [DIN_WIDTH-1:0]   mem_q [WR_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]          rd_ptr_nxt;
  logic [AW:0]            count_q, count_d;
  logic [2*DIN_WIDTH-1:0] dout_q, dout_d;
  logic                   wr_acc, rd_acc;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q < CNT_PAIR);
  assign dout  = dout_q;

  // Acceptance uses pre-edge flags only, so a same-edge read never frees room
  // for a write and a same-edge write never completes a pair for a read.
  always_comb begin
    wr_acc     = wr_en && !full;
    rd_acc     = rd_en && !empty;
    rd_ptr_nxt = rd_ptr_q + AW'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dout_d     = dout_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(2);
      dout_d   = {mem_q[rd_ptr_q], mem_q[rd_ptr_nxt]};
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(2);
      2'b11:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is not reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (!srst && wr_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: tb/tb_fifo_w8_r16.sv
// Scoreboard bench for fifo_w8_r16: a byte-queue model predicts each read word,
// and a monitor compares dout and the flags after every clock edge.
module tb_fifo_w8_r16;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [15:0] dout;
  logic        full, empty;

  always #5 clk = ~clk;

  fifo_w8_r16 #(.DIN_WIDTH(8), .WR_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .srst  (srst),
    .din   (din),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  // Reference model: stored bytes in arrival order, plus expected read words.
  logic [7:0]  mq[$];
  logic [15:0] exp_q[$];

  logic rd_fire = 1'b0, rst_fire = 1'b0, exp_empty_n = 1'b1, exp_full_n = 1'b0, arm = 1'b0;
  logic rd_pend = 1'b0, rst_pend = 1'b0, exp_empty_s = 1'b1, exp_full_s = 1'b0, arm_s = 1'b0;
  logic [15:0] cur_exp = 16'h0000;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    rd_pend     <= rd_fire;
    rst_pend    <= rst_fire;
    exp_empty_s <= exp_empty_n;
    exp_full_s  <= exp_full_n;
    arm_s       <= arm;
  end

  // Monitor: consumes one expected word per predicted accepted read.
  always @(negedge clk) begin
    if (arm_s) begin
      if (rst_pend) begin
        cur_exp = 16'h0000;
      end else if (rd_pend) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL scoreboard: read predicted with no expected word at %0t", $time);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      chk("dout",  dout,  cur_exp);
      chk("empty", {15'd0, empty}, {15'd0, exp_empty_s});
      chk("full",  {15'd0, full},  {15'd0, exp_full_s});
    end
  end

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic rst);
    logic [7:0] b0, b1;
    bit ra, wa;
    srst = rst; wr_en = w; din = d; rd_en = r;
    rd_fire = 1'b0; rst_fire = rst;
    if (rst) begin
      mq.delete();
    end else begin
      ra = r && (mq.size() >= 2);
      wa = w && (mq.size() < DEPTH);
      if (ra) begin
        b0 = mq.pop_front();
        b1 = mq.pop_front();
        exp_q.push_back({b0, b1});
        rd_fire = 1'b1;
      end
      if (wa) mq.push_back(d);
    end
    exp_empty_n = (mq.size() < 2);
    exp_full_n  = (mq.size() == DEPTH);
    arm = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d); cycle(1'b1, d, 1'b0, 1'b0); endtask
  task automatic rd();                    cycle(1'b0, 8'h00, 1'b1, 1'b0); endtask
  task automatic idle();                  cycle(1'b0, 8'h00, 1'b0, 1'b0); endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    // Reset with both requests asserted
    cycle(1'b1, 8'h55, 1'b1, 1'b1);
    idle();
    // Basic pair
    wr(8'h12); wr(8'h34); rd(); idle();
    // Constant stream
    for (int i = 0; i < 4; i++) wr(8'h69);
    rd(); rd(); idle();
    // Fill, overflow attempt, drain
    for (int i = 0; i < 16; i++) wr(8'(i));
    wr(8'hAA);
    for (int i = 0; i < 8; i++) rd();
    idle();
    // Read while empty holds dout
    rd(); rd(); idle();
    // Simultaneous at count 15 and at count 16
    for (int i = 0; i < 15; i++) wr(8'(8'h40 + i));
    cycle(1'b1, 8'hC1, 1'b1, 1'b0);
    wr(8'hC2); wr(8'hC3);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) rd();
    idle();
    // Stream 40 bytes with concurrent random reads across pointer wrap
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 12; i++) rd();
    // Reset with six bytes stored; stale data must never reappear
    for (int i = 0; i < 6; i++) wr(8'(8'hD0 + i));
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    rd(); wr(8'hA1); rd(); wr(8'hB2); rd(); idle();
    // Random mix including occasional resets
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 59) == 0));
    for (int i = 0; i < 10; i++) rd();
    idle(); idle();
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL leftover: %0d expected words never observed, required 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
